// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared state encodings, error codes and default timing for the PS/2 host transmitter.
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_REQ,
    S_BITS,
    S_ACK,
    S_WAITIDLE
  } state_e;
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_START,
    ERR_PACKET,
    ERR_NOACK
  } err_e;
  localparam int DEF_INHIBIT_CYCLES = 2500;
  localparam int DEF_START_TIMEOUT  = 375000;
  localparam int DEF_PACKET_TIMEOUT = 50000;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/ps2_host_tx_stab.sv
// ps2_host_tx_stab: two-flop synchronizer for an asynchronous PS/2 pin; resets to the idle-high level.
module ps2_host_tx_stab (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], din};
  assign dout = sync_q[1];
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else sync_q <= sync_d;
  end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter sending one command byte over open-drain ps2c/ps2d.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int PACKET_TIMEOUT = DEF_PACKET_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic       rx_inhibit
);
  localparam int TW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT, PACKET_TIMEOUT));
  logic c_s, d_s, c_prev_q, fall, pkt_to, abort;
  logic [1:0] abort_code;
  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [9:0] shift_q, shift_d;
  logic ps2d_oe_q, ps2d_oe_d, done_q, done_d, error_q, error_d;
  logic [1:0] err_code_q, err_code_d;
  ps2_host_tx_stab u_stab_c (.clk(clk), .reset(reset), .din(ps2c_in), .dout(c_s));
  ps2_host_tx_stab u_stab_d (.clk(clk), .reset(reset), .din(ps2d_in), .dout(d_s));
  assign fall = c_prev_q & ~c_s;
  assign pkt_to = timer_q == TW'(PACKET_TIMEOUT - 1);
  assign ps2c_oe = (state_q == S_INHIBIT) || (state_q == S_START);
  assign ps2d_oe = ps2d_oe_q;
  assign busy = state_q != S_IDLE;
  assign rx_inhibit = busy;
  assign done = done_q;
  assign error = error_q;
  assign err_code = err_code_q;
  always_comb begin
    state_d = state_q;
    timer_d = (&timer_q) ? timer_q : timer_q + TW'(1);
    bitcnt_d = bitcnt_q;
    shift_d = shift_q;
    ps2d_oe_d = ps2d_oe_q;
    done_d = 1'b0;
    error_d = 1'b0;
    err_code_d = err_code_q;
    abort = 1'b0;
    abort_code = ERR_NONE;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (tx_start) begin
          state_d = S_INHIBIT;
          shift_d = {1'b1, ~^tx_data, tx_data};
          bitcnt_d = '0;
          err_code_d = ERR_NONE;
        end
      end
      S_INHIBIT: if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
        state_d = S_START;
        ps2d_oe_d = 1'b1;
      end
      S_START: begin
        state_d = S_REQ;
        timer_d = '0;
      end
      // A device edge always beats a timeout landing in the same cycle.
      S_REQ: begin
        if (fall) begin
          ps2d_oe_d = ~shift_q[0];
          shift_d = {1'b0, shift_q[9:1]};
          bitcnt_d = 4'd1;
          timer_d = '0;
          state_d = S_BITS;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          abort = 1'b1;
          abort_code = ERR_START;
        end
      end
      S_BITS: begin
        if (fall) begin
          ps2d_oe_d = ~shift_q[0];
          shift_d = {1'b0, shift_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          state_d = (bitcnt_q == 4'd9) ? S_ACK : S_BITS;
        end else if (pkt_to) begin
          abort = 1'b1;
          abort_code = ERR_PACKET;
        end
      end
      S_ACK: begin
        if (fall) begin
          state_d = S_WAITIDLE;
          abort = d_s;
          abort_code = ERR_NOACK;
        end else if (pkt_to) begin
          abort = 1'b1;
          abort_code = ERR_PACKET;
        end
      end
      S_WAITIDLE: begin
        if (c_s && d_s) begin
          done_d = 1'b1;
          state_d = S_IDLE;
        end else if (pkt_to) begin
          abort = 1'b1;
          abort_code = ERR_PACKET;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      ps2d_oe_d = 1'b0;
      error_d = 1'b1;
      err_code_d = abort_code;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bitcnt_q <= '0;
      shift_q <= '0;
      ps2d_oe_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      err_code_q <= ERR_NONE;
      c_prev_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q <= shift_d;
      ps2d_oe_q <= ps2d_oe_d;
      done_q <= done_d;
      error_q <= error_d;
      err_code_q <= err_code_d;
      c_prev_q <= c_s;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a behavioural PS/2 device clocking at 40 clk per half-period.
module tb_ps2_host_tx;
  logic clk = 1'b0, reset = 1'b1, tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe, busy, done, error, rx_inhibit;
  logic [1:0] err_code;
  logic dev_c = 1'b0, dev_d = 1'b0;
  int dev_idx = 0;
  int errors = 0, checks = 0, done_cnt = 0, err_cnt = 0;
  always #5 clk = ~clk;
  assign ps2c_in = ~(ps2c_oe | dev_c);
  assign ps2d_in = ~(ps2d_oe | dev_d);
  ps2_host_tx #(.INHIBIT_CYCLES(20), .START_TIMEOUT(200), .PACKET_TIMEOUT(2000)) dut (
    .clk(clk), .reset(reset), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .rx_inhibit(rx_inhibit)
  );
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic device(input int nclk, input bit ack, output logic [10:0] bits);
    bit found = 0;
    bits = '0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (busy && ps2c_in && !ps2d_in) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL dev_request: request seen=0, want 1");
      return;
    end
    bits[0] = ps2d_in;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= nclk; i++) begin
      dev_idx = i;
      if (i == 11 && ack) dev_d = 1'b1;
      dev_c = 1'b1;
      repeat (40) @(negedge clk);
      dev_c = 1'b0;
      if (i <= 10) bits[i] = ps2d_in;
      dev_d = 1'b0;
      repeat (40) @(negedge clk);
    end
    dev_idx = 0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int k = 0; k < 6000 && !ok; k++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle: busy stuck=1, want 0", name);
    end
    @(negedge clk);
  endtask

  task automatic full_tx(input logic [7:0] b, input string name);
    logic [10:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    send(b);
    checks++;
    if ({busy, ps2c_oe, ps2d_oe} !== 3'b110) begin
      errors++;
      $display("FAIL %s_inhibit: busy/c_oe/d_oe=%b, want 110", name, {busy, ps2c_oe, ps2d_oe});
    end
    device(11, 1, bits);
    wait_idle(name);
    checks++;
    if (bits !== frame(b)) begin
      errors++;
      $display("FAIL %s_frame: device saw %b, want %b", name, bits, frame(b));
    end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
      errors++;
      $display("FAIL %s_pulses: done=%0d error=%0d, want 1 0", name, done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if ({err_code, ps2c_oe, ps2d_oe} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_end: err_code/oe=%b, want 0000", name, {err_code, ps2c_oe, ps2d_oe});
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2c_oe, ps2d_oe, busy, rx_inhibit, done, error, err_code} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 00000000",
               {ps2c_oe, ps2d_oe, busy, rx_inhibit, done, error, err_code});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2c_oe, ps2d_oe, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got %b, want 000", {ps2c_oe, ps2d_oe, busy});
    end
  endtask

  task automatic test_ed;
    full_tx(8'hED, "tx_ed");
    checks++;
    if (frame(8'hED) !== 11'b11_1110_1101_0) begin
      errors++;
      $display("FAIL ed_parity: frame %b, want 11111011010", frame(8'hED));
    end
  endtask

  task automatic test_parity;
    full_tx(8'h00, "tx_00");
    full_tx(8'h01, "tx_01");
  endtask

  task automatic test_start_timeout;
    int n = 0, e0 = err_cnt;
    bit seen = 0;
    send(8'hA5);
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (busy && !ps2c_oe && ps2d_oe) seen = 1;
    end
    while (seen && !error && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!seen || n !== 200) begin
      errors++;
      $display("FAIL start_to_latency: req=%0d cycles=%0d, want 1 200", seen, n);
    end
    checks++;
    if ({err_code, ps2c_oe, ps2d_oe, busy} !== 5'b01000) begin
      errors++;
      $display("FAIL start_to_state: err_code/c/d/busy=%b, want 01000", {err_code, ps2c_oe, ps2d_oe, busy});
    end
    @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1 || error !== 1'b0) begin
      errors++;
      $display("FAIL start_to_pulse: count=%0d error=%b, want 1 0", err_cnt - e0, error);
    end
  endtask

  task automatic test_packet_timeout;
    logic [10:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    send(8'h3C);
    device(5, 0, bits);
    wait_idle("pkt_to");
    checks++;
    if (err_code !== 2'd2 || err_cnt - e0 !== 1 || done_cnt !== d0) begin
      errors++;
      $display("FAIL pkt_to_result: err_code=%0d errors=%0d dones=%0d, want 2 1 0",
               err_code, err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
      errors++;
      $display("FAIL pkt_to_release: oe=%b, want 00", {ps2c_oe, ps2d_oe});
    end
    full_tx(8'hF4, "tx_f4");
  endtask

  task automatic test_no_ack;
    logic [10:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    send(8'h5A);
    device(11, 0, bits);
    wait_idle("no_ack");
    checks++;
    if (err_code !== 2'd3 || err_cnt - e0 !== 1 || done_cnt !== d0) begin
      errors++;
      $display("FAIL no_ack_result: err_code=%0d errors=%0d dones=%0d, want 3 1 0",
               err_code, err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (bits !== frame(8'h5A)) begin
      errors++;
      $display("FAIL no_ack_frame: device saw %b, want %b", bits, frame(8'h5A));
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] bits;
    int d0 = done_cnt, e0 = err_cnt;
    send(8'h99);
    fork
      device(11, 1, bits);
      begin
        bit hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
          @(negedge clk);
          if (dev_idx == 4) hit = 1;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (!hit || busy !== 1'b1) begin
          errors++;
          $display("FAIL rst_mid_busy: reached=%0d busy=%b, want 1 1", hit, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ps2c_oe, ps2d_oe, busy, rx_inhibit, done, error} !== 6'b000000) begin
          errors++;
          $display("FAIL rst_mid_release: got %b, want 000000",
                   {ps2c_oe, ps2d_oe, busy, rx_inhibit, done, error});
        end
        reset = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || err_cnt !== e0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pulses: dones=%0d errors=%0d busy=%b, want 0 0 0",
               done_cnt - d0, err_cnt - e0, busy);
    end
  endtask

  task automatic test_busy_ignore;
    logic [10:0] bits;
    int d0 = done_cnt, extra = 0;
    send(8'hED);
    fork
      device(11, 1, bits);
      begin
        bit hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
          @(negedge clk);
          if (dev_idx == 3) hit = 1;
        end
        tx_data = 8'h12;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    wait_idle("busy_ign");
    repeat (300) begin
      @(negedge clk);
      if (busy || ps2c_oe || ps2d_oe) extra++;
    end
    checks++;
    if (bits !== frame(8'hED)) begin
      errors++;
      $display("FAIL busy_ign_frame: device saw %b, want %b", bits, frame(8'hED));
    end
    checks++;
    if (extra !== 0 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL busy_ign_queue: busy cycles=%0d dones=%0d, want 0 1", extra, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_ed();
    test_parity();
    test_start_timeout();
    test_packet_timeout();
    test_no_ack();
    test_reset_mid();
    test_busy_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
